// File: rtl/rcad_mult_seq_if.sv
// Bundle between a requester/adder environment (master) and the shift-and-add
// controller (slave): request handshake, product result and rcad adder drive/return.
interface rcad_mult_seq_if #(
  parameter int W = 4
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_m;
  logic [W-1:0]   add_s;
  logic [W-1:0]   add_c;
  logic           add_ov;

  modport master (
    output start, a, b, sgn,
    input  busy, done, p,
    input  add_a, add_b, add_m,
    output add_s, add_c, add_ov
  );

  modport slave (
    input  start, a, b, sgn,
    output busy, done, p,
    output add_a, add_b, add_m,
    input  add_s, add_c, add_ov
  );
endinterface

// File: rtl/rcad_mult_seq.sv
// Sequential shift-and-add multiplier sharing one external W-bit rcad adder.
// Define RCAD_MULT_SIGNED_EN to compile in the Booth radix-2 signed path.
module rcad_mult_seq #(
  parameter int W = 4
) (
  input logic             clk,
  input logic             rst_n,
  rcad_mult_seq_if.slave  bus
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   a_q, q_q, m_q;
  logic           c_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, done_q;
  logic [2*W-1:0] p_q;
  logic [W-1:0]   a_d;
  logic           c_d;
  logic           add_m_d;
  logic           unused_ok;

`ifdef RCAD_MULT_SIGNED_EN
  logic           q1_q;
  logic           s_r_q;

  assign unused_ok = ^{bus.add_c[W-2:0]};
`else
  assign unused_ok = ^{bus.sgn, bus.add_ov, bus.add_c[W-2:0]};
`endif

  // C carries the unsigned carry-out, or the overflow-corrected sign E in signed mode
  always_comb begin
    a_d     = a_q;
    c_d     = 1'b0;
    add_m_d = 1'b0;
`ifdef RCAD_MULT_SIGNED_EN
    if (s_r_q) begin
      c_d = a_q[W-1];
      case ({q_q[0], q1_q})
        2'b01: begin
          a_d = bus.add_s;
          c_d = bus.add_s[W-1] ^ bus.add_ov;
        end
        2'b10: begin
          add_m_d = (state_q == S_ADD);
          a_d     = bus.add_s;
          c_d     = bus.add_s[W-1] ^ bus.add_ov;
        end
        default: ;
      endcase
    end else if (q_q[0]) begin
      a_d = bus.add_s;
      c_d = bus.add_c[W-1];
    end
`else
    if (q_q[0]) begin
      a_d = bus.add_s;
      c_d = bus.add_c[W-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
`ifdef RCAD_MULT_SIGNED_EN
      q1_q    <= 1'b0;
      s_r_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            m_q     <= bus.a;
            q_q     <= bus.b;
            a_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
`ifdef RCAD_MULT_SIGNED_EN
            q1_q    <= 1'b0;
            s_r_q   <= bus.sgn;
`endif
          end
        end
        S_ADD: begin
          a_q     <= a_d;
          c_q     <= c_d;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          // {C,A,Q,q_1} shifted right; C is kept so it replicates as sign
          a_q   <= {c_q, a_q[W-1:1]};
          q_q   <= {a_q[0], q_q[W-1:1]};
          cnt_q <= cnt_q + 1'b1;
`ifdef RCAD_MULT_SIGNED_EN
          q1_q  <= q_q[0];
`endif
          if (cnt_q == CW'(W - 1)) begin
            p_q     <= {c_q, a_q, q_q[W-1:1]};
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_ADD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.p     = p_q;
  assign bus.add_a = a_q;
  assign bus.add_b = m_q;
  assign bus.add_m = add_m_d;
endmodule
